dmem_responder: RTL and testbench

- Word-addressed data-memory slave that answers load/store requests from the processor's memory port over a valid/ready request/response handshake.
- Inserts a programmable number of wait states, so the core's load/store path can be exercised against non-zero-latency memory.
- Sits between the processor datapath (initiator) and the backing RAM array it owns.

---
 rtl/dmem_responder_if.sv | 42 ++++
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//
// Purpose: request/response handshake bundle between a processor memory port
// (initiator) and the dmem_responder data-memory slave.
//
// Signals:
//   req_valid  initiator -> responder  request present
//   req_ready  responder -> initiator  responder can take a request
//   req_we     initiator -> responder  1 = store, 0 = load
//   req_addr   initiator -> responder  byte address (32 bits)
//   req_wdata  initiator -> responder  store data (32 bits)
//   req_wstrb  initiator -> responder  store byte enables (4 bits)
//   rsp_valid  responder -> initiator  response present
//   rsp_ready  initiator -> responder  initiator takes the response
//   rsp_rdata  responder -> initiator  load data (32 bits)
//   rsp_err    responder -> initiator  request rejected
//
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose: word-addressed data-memory slave with a programmable number of
// wait states between request acceptance and the memory access. Only one
// request is ever outstanding; req_ready is a pure function of state.
//
// Parameters:
//   DEPTH        number of 32-bit words in the backing array
//   WAIT_CYCLES  wait-state cycles before the access cycle (0 allowed)
//
// Ports:
//   clk  system clock, all state on the rising edge
//   rst  asynchronous active-high reset (the RAM contents survive it)
//   bus  dmem_responder_if.slave request/response handshake
//
// Optional feature (macro DMEM_ERR_CHECK_EN):
//   defined   - misaligned or out-of-range accesses are rejected with
//               rsp_err=1, rsp_rdata=0 and no memory write
//   undefined - address bits [1:0] are ignored, the word index wraps modulo
//               DEPTH, rsp_err is always 0
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;

  logic               lat_we;
  logic [29:0]        lat_word;
  logic [31:0]        lat_wdata;
  logic [3:0]         lat_wstrb;

  logic               acc_err;
  logic [IDX_W-1:0]   mem_idx;
  logic               mem_wr;

  // The backing array starts out all-zero and is deliberately left out of
  // the reset path, so a reset never wipes committed stores.
  logic [31:0] mem [DEPTH] = '{default: 32'h0000_0000};

  // Word index of the latched request. The modulo keeps the index inside the
  // array for any DEPTH; when error checking is on, out-of-range requests
  // never touch the array anyway.
  assign mem_idx = IDX_W'({2'b00, lat_word} % 32'(DEPTH));

`ifdef DMEM_ERR_CHECK_EN
  logic lat_misaligned;

  // A request is rejected when it is not word aligned or lies past the end
  // of the array.
  assign acc_err = lat_misaligned || ({2'b00, lat_word} >= 32'(DEPTH));
`else
  logic unused_addr_lsbs;

  // Byte offset within the word carries no meaning without error checking.
  assign unused_addr_lsbs = ^bus.req_addr[1:0];
  assign acc_err          = 1'b0;
`endif

  assign mem_wr = (state == ACCESS) && lat_we && !acc_err;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // Control FSM: accept in IDLE, burn the wait states in WAIT, touch the
  // array for one cycle in ACCESS, then hold the response in RESP until the
  // initiator takes it. All handshake outputs are registered here so that
  // req_ready can never depend combinationally on req_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      lat_we      <= 1'b0;
      lat_word    <= '0;
      lat_wdata   <= '0;
      lat_wstrb   <= '0;
`ifdef DMEM_ERR_CHECK_EN
      lat_misaligned <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            lat_we      <= bus.req_we;
            lat_word    <= bus.req_addr[31:2];
            lat_wdata   <= bus.req_wdata;
            lat_wstrb   <= bus.req_wstrb;
`ifdef DMEM_ERR_CHECK_EN
            lat_misaligned <= (bus.req_addr[1:0] != 2'b00);
`endif
            wait_cnt    <= CNT_W'(WAIT_CYCLES);
            req_ready_q <= 1'b0;
            state       <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt <= CNT_W'(1)) begin
            state <= ACCESS;
          end
        end

        ACCESS: begin
          // Stores and rejected requests return zero data.
          if (lat_we || acc_err) begin
            rsp_rdata_q <= '0;
          end else begin
            rsp_rdata_q <= mem[mem_idx];
          end
          rsp_err_q   <= acc_err;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane write port. The write lands on the edge that ends ACCESS, so a
  // reset arriving before that edge discards the store and one arriving
  // after it leaves the store in place.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_wstrb[b]) begin
          mem[mem_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Purpose: directed self-checking bench for dmem_responder. Two instances are
// built from the same source: one with two wait states and one with none.
// A select flag steers the shared stimulus to one instance at a time and
// multiplexes that instance's outputs back for checking.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk;
  logic rst;

  logic        sel0;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_ready;

  logic        obs_req_ready;
  logic        obs_rsp_valid;
  logic [31:0] obs_rsp_rdata;
  logic        obs_rsp_err;

  int checks;
  int errors;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // Steer the initiator signals to the selected instance only; the other
  // instance sees no valid request and no response acceptance.
  assign bus2.req_valid = req_valid && !sel0;
  assign bus0.req_valid = req_valid &&  sel0;
  assign bus2.rsp_ready = rsp_ready && !sel0;
  assign bus0.rsp_ready = rsp_ready &&  sel0;
  assign bus2.req_we    = req_we;
  assign bus0.req_we    = req_we;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_addr  = req_addr;
  assign bus2.req_wdata = req_wdata;
  assign bus0.req_wdata = req_wdata;
  assign bus2.req_wstrb = req_wstrb;
  assign bus0.req_wstrb = req_wstrb;

  assign obs_req_ready = sel0 ? bus0.req_ready : bus2.req_ready;
  assign obs_rsp_valid = sel0 ? bus0.rsp_valid : bus2.rsp_valid;
  assign obs_rsp_rdata = sel0 ? bus0.rsp_rdata : bus2.rsp_rdata;
  assign obs_rsp_err   = sel0 ? bus0.rsp_err   : bus2.rsp_err;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on a miss counts the failure and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reset values of every registered output of the selected instance.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, {31'd0, obs_req_ready}, 32'd1);
    checkOutput({tag, "_rsp_valid"}, {31'd0, obs_rsp_valid}, 32'd0);
    checkOutput({tag, "_rsp_rdata"}, obs_rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"},   {31'd0, obs_rsp_err},   32'd0);
  endtask

  // Issue one request, wait (bounded) for the response, optionally hold
  // rsp_ready low for 'hold' cycles while checking stability, then complete
  // the handshake and confirm the return to idle.
  task automatic applyStimulus(input string tag, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int hold,
                               input int exp_lat, input logic [31:0] exp_rdata,
                               input logic exp_err);
    int          lat;
    logic [31:0] first_rdata;
    logic        first_err;
    @(negedge clk);
    checkOutput({tag, "_ready_before"}, {31'd0, obs_req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hA5A5_A5A5;
    req_wstrb = 4'hF;
    lat = 0;
    while (!obs_rsp_valid && lat < 50) begin
      checkOutput({tag, "_ready_busy"}, {31'd0, obs_req_ready}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_rsp_valid"}, {31'd0, obs_rsp_valid}, 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_rdata"}, obs_rsp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'd0, obs_rsp_err}, {31'd0, exp_err});
    first_rdata = obs_rsp_rdata;
    first_err   = obs_rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, {31'd0, obs_rsp_valid}, 32'd1);
      checkOutput({tag, "_hold_rdata"}, obs_rsp_rdata, first_rdata);
      checkOutput({tag, "_hold_err"}, {31'd0, obs_rsp_err}, {31'd0, first_err});
      checkOutput({tag, "_hold_ready"}, {31'd0, obs_req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, {31'd0, obs_rsp_valid}, 32'd0);
    checkOutput({tag, "_done_ready"}, {31'd0, obs_req_ready}, 32'd1);
  endtask

  // Directed sequence: reset, full and partial stores, back-pressure, reset
  // during wait states, zero-wait instance, then the address-error/wrap
  // behaviour of whichever build is compiled.
  initial begin
    checks    = 0;
    errors    = 0;
    sel0      = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("st_full",   1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 3, 32'h0, 1'b0);
    applyStimulus("ld_full",   1'b0, 32'h10, 32'h0,         4'b0000, 0, 3, 32'hDEAD_BEEF, 1'b0);
    applyStimulus("st_byte0",  1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 3, 32'h0, 1'b0);
    applyStimulus("ld_byte0",  1'b0, 32'h10, 32'h0,         4'b0000, 0, 3, 32'hDEAD_BEAA, 1'b0);
    applyStimulus("ld_hold",   1'b0, 32'h10, 32'h0,         4'b0000, 5, 3, 32'hDEAD_BEAA, 1'b0);

    // Reset while a store to 0x40 sits in its wait states.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h1234_5678;
    req_wstrb = 4'b1111;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("mid_ready_busy", {31'd0, obs_req_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("ld_discard", 1'b0, 32'h40, 32'h0, 4'b0000, 0, 3, 32'h0, 1'b0);

    // Zero-wait instance.
    sel0 = 1'b1;
    applyStimulus("w0_ld_blank", 1'b0, 32'h20, 32'h0,         4'b0000, 0, 1, 32'h0, 1'b0);
    applyStimulus("w0_st_nostb", 1'b1, 32'h24, 32'hFFFF_FFFF, 4'b0000, 0, 1, 32'h0, 1'b0);
    applyStimulus("w0_ld_nostb", 1'b0, 32'h24, 32'h0,         4'b0000, 0, 1, 32'h0, 1'b0);
    applyStimulus("w0_st_hi",    1'b1, 32'h28, 32'hCAFE_BABE, 4'b1100, 0, 1, 32'h0, 1'b0);
    applyStimulus("w0_ld_hi",    1'b0, 32'h28, 32'h0,         4'b0000, 2, 1, 32'hCAFE_0000, 1'b0);
    sel0 = 1'b0;

`ifdef DMEM_ERR_CHECK_EN
    applyStimulus("err_ld_mis",  1'b0, 32'h13,   32'h0,        4'b0000, 0, 3, 32'h0, 1'b1);
    applyStimulus("err_st_oor",  1'b1, 32'h1000, 32'h0000_0055, 4'b1111, 0, 3, 32'h0, 1'b1);
    applyStimulus("err_ld_zero", 1'b0, 32'h0,    32'h0,        4'b0000, 0, 3, 32'h0, 1'b0);
    applyStimulus("err_ld_ok",   1'b0, 32'h10,   32'h0,        4'b0000, 0, 3, 32'hDEAD_BEAA, 1'b0);
`else
    applyStimulus("wrap_st",     1'b1, 32'h1000, 32'h0000_0055, 4'b1111, 0, 3, 32'h0, 1'b0);
    applyStimulus("wrap_ld",     1'b0, 32'h0,    32'h0,        4'b0000, 0, 3, 32'h0000_0055, 1'b0);
    applyStimulus("lsb_ignore",  1'b0, 32'h13,   32'h0,        4'b0000, 0, 3, 32'hDEAD_BEAA, 1'b0);
    applyStimulus("wrap_ld_hi",  1'b0, 32'h1010, 32'h0,        4'b0000, 0, 3, 32'hDEAD_BEAA, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
